// File: rtl/arbitro_rr_pkg.sv
// Shared constants and FSM encoding for the round-robin crossbar arbiter.
// Holds word width, port count, destination field position and state codes.
package arbitro_rr_pkg;

  localparam int DATA_W = 10;
  localparam int NPORT  = 4;
  localparam int SEL_W  = 2;
  localparam int DST_HI = DATA_W - 1;
  localparam int DST_LO = DATA_W - SEL_W;

  typedef enum logic [3:0] {
    ST_RESET  = 4'b0001,
    ST_INIT   = 4'b0010,
    ST_IDLE   = 4'b0100,
    ST_ACTIVE = 4'b1000
  } state_t;

endpackage

// File: rtl/arbitro_rr_rr_sel.sv
// Round-robin selector: first requester after 'last' wins.
// Ports: req (requests), last (previous winner) -> gnt (one-hot), valid.
module rr_sel
  import arbitro_rr_pkg::*;
(
  input  logic [NPORT-1:0] req,
  input  logic [SEL_W-1:0] last,
  output logic [NPORT-1:0] gnt,
  output logic             valid
);

  logic [SEL_W-1:0] idx;

  // Index arithmetic wraps naturally because NPORT == 2**SEL_W.
  always_comb begin
    gnt   = '0;
    valid = 1'b0;
    idx   = '0;
    for (int k = 1; k <= NPORT; k++) begin
      idx = last + SEL_W'(k);
      if (!valid && req[idx]) begin
        gnt[idx] = 1'b1;
        valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arbitro_rr.sv
// 4x4 round-robin crossbar: pops one source FIFO per cycle, pushes to dest.
// Ports: clk, reset, init, fifo_empty, P0..P3, almost_full -> pop, Out0..3,
// push, state, idle.
module arbitro_rr #(
  parameter int DATA_W = arbitro_rr_pkg::DATA_W,
  parameter int NPORT  = arbitro_rr_pkg::NPORT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init,
  input  logic [NPORT-1:0]  fifo_empty,
  input  logic [DATA_W-1:0] P0,
  input  logic [DATA_W-1:0] P1,
  input  logic [DATA_W-1:0] P2,
  input  logic [DATA_W-1:0] P3,
  input  logic [NPORT-1:0]  almost_full,
  output logic [NPORT-1:0]  pop,
  output logic [DATA_W-1:0] Out0,
  output logic [DATA_W-1:0] Out1,
  output logic [DATA_W-1:0] Out2,
  output logic [DATA_W-1:0] Out3,
  output logic [NPORT-1:0]  push,
  output logic [3:0]        state,
  output logic              idle
);

  import arbitro_rr_pkg::*;

  localparam int DHI = DATA_W - 1;
  localparam int DLO = DATA_W - SEL_W;

  state_t            state_q;
  logic [SEL_W-1:0]  last_q;
  logic [DATA_W-1:0] out_q [NPORT];
  logic [NPORT-1:0]  push_q;

  logic [DATA_W-1:0] pw [NPORT];
  logic [NPORT-1:0]  elig;
  logic [NPORT-1:0]  gnt;
  logic              gv;
  logic              grant_en;
  logic [SEL_W-1:0]  g;
  logic [DATA_W-1:0] gw;
  logic [SEL_W-1:0]  gdst;

  assign pw[0] = P0;
  assign pw[1] = P1;
  assign pw[2] = P2;
  assign pw[3] = P3;

  // A source is skipped if its head word targets a nearly full destination.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NPORT; i++)
      elig[i] = ~fifo_empty[i] & ~almost_full[pw[i][DHI:DLO]];
  end

  rr_sel u_sel (
    .req   (elig),
    .last  (last_q),
    .gnt   (gnt),
    .valid (gv)
  );

  assign grant_en = (state_q == ST_ACTIVE) & ~init & ~reset & gv;
  assign pop      = grant_en ? gnt : '0;

  always_comb begin
    g = '0;
    for (int i = 0; i < NPORT; i++)
      if (gnt[i]) g = SEL_W'(i);
  end

  assign gw   = pw[g];
  assign gdst = gw[DHI:DLO];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RESET;
      last_q  <= '1;
      push_q  <= '0;
      for (int i = 0; i < NPORT; i++) out_q[i] <= '0;
    end else begin
      push_q <= '0;
      for (int i = 0; i < NPORT; i++) out_q[i] <= '0;
      if (grant_en) begin
        last_q        <= g;
        push_q[gdst]  <= 1'b1;
        out_q[gdst]   <= gw;
      end else if (init) begin
        last_q <= '1;
      end
      if (init) begin
        state_q <= ST_INIT;
      end else begin
        unique case (state_q)
          ST_RESET:  state_q <= ST_INIT;
          ST_INIT:   state_q <= ST_IDLE;
          ST_IDLE:   if (!(&fifo_empty)) state_q <= ST_ACTIVE;
          ST_ACTIVE: if (&fifo_empty) state_q <= ST_IDLE;
          default:   state_q <= ST_INIT;
        endcase
      end
    end
  end

  // Reset blanks the outputs immediately so an in-flight word is dropped.
  assign Out0  = reset ? '0 : out_q[0];
  assign Out1  = reset ? '0 : out_q[1];
  assign Out2  = reset ? '0 : out_q[2];
  assign Out3  = reset ? '0 : out_q[3];
  assign push  = reset ? '0 : push_q;
  assign state = state_q;
  assign idle  = ~reset & (state_q == ST_IDLE) & (&fifo_empty);

endmodule

// File: tb/tb_arbitro_rr.sv
// Self-checking bench for arbitro_rr: directed scenarios plus random traffic
// compared against a cycle-level behavioural model.
module tb_arbitro_rr;

  logic       clk = 1'b0;
  logic       reset, init;
  logic [3:0] fe, af;
  logic [9:0] p [4];
  logic [3:0] pop, push, state;
  logic [9:0] o0, o1, o2, o3;
  logic       idle;

  always #5 clk = ~clk;

  arbitro_rr dut (
    .clk         (clk),
    .reset       (reset),
    .init        (init),
    .fifo_empty  (fe),
    .P0          (p[0]),
    .P1          (p[1]),
    .P2          (p[2]),
    .P3          (p[3]),
    .almost_full (af),
    .pop         (pop),
    .Out0        (o0),
    .Out1        (o1),
    .Out2        (o2),
    .Out3        (o3),
    .push        (push),
    .state       (state),
    .idle        (idle)
  );

  int errors = 0;
  int checks = 0;

  logic [3:0]  m_state;
  int          m_last;
  bit          m_pv;
  int          m_pd;
  logic [9:0]  m_pw;

  int          exp_g;
  logic [3:0]  exp_pop, exp_push;
  logic [39:0] exp_out;
  logic        exp_idle;
  logic [39:0] got_out;

  assign got_out = {o3, o2, o1, o0};

  function automatic bit elig(int i);
    logic [9:0] w;
    w = p[i];
    return !fe[i] && !af[w[9:8]];
  endfunction

  task automatic settle();
    @(negedge clk);
    exp_g = -1;
    if (m_state == 4'b1000 && !init && !reset)
      for (int k = 1; k <= 4; k++) begin
        int i;
        i = (m_last + k) % 4;
        if (exp_g < 0 && elig(i)) exp_g = i;
      end
    exp_pop  = (exp_g >= 0) ? 4'(1 << exp_g) : 4'b0;
    exp_push = '0;
    exp_out  = '0;
    if (!reset && m_pv) begin
      exp_push[m_pd]        = 1'b1;
      exp_out[m_pd*10 +: 10] = m_pw;
    end
    exp_idle = !reset && m_state == 4'b0100 && fe == 4'hF;
  endtask

  task automatic tick();
    logic [9:0] w;
    @(posedge clk);
    if (reset) begin
      m_state = 4'b0001;
      m_last  = 3;
      m_pv    = 0;
    end else begin
      m_pv = (exp_g >= 0);
      if (m_pv) begin
        w      = p[exp_g];
        m_pw   = w;
        m_pd   = int'(w[9:8]);
        m_last = exp_g;
      end else if (init) begin
        m_last = 3;
      end
      if (init) m_state = 4'b0010;
      else case (m_state)
        4'b0001: m_state = 4'b0010;
        4'b0010: m_state = 4'b0100;
        4'b0100: if (fe != 4'hF) m_state = 4'b1000;
        4'b1000: if (fe == 4'hF) m_state = 4'b0100;
        default: m_state = 4'b0010;
      endcase
    end
    #1;
  endtask

  task automatic go_idle();
    init = 1'b1;
    settle();
    tick();
    init = 1'b0;
    settle();
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; init = 1'b0; fe = 4'hF; af = 4'h0;
    for (int i = 0; i < 4; i++) p[i] = '0;
    exp_g = -1;
    tick();
    settle();
    checks++;
    if (state !== 4'b0001) begin
      errors++; $display("FAIL reset_state got=%b exp=0001", state);
    end
    checks++;
    if (pop !== 4'b0 || push !== 4'b0 || got_out !== 40'b0 || idle !== 1'b0) begin
      errors++;
      $display("FAIL reset_outs pop=%b push=%b out=%h idle=%b exp all 0",
               pop, push, got_out, idle);
    end
    tick();
    reset = 1'b0; init = 1'b1;
    settle();
    tick();
    init = 1'b0;
    settle();
    checks++;
    if (state !== 4'b0010) begin
      errors++; $display("FAIL init_state got=%b exp=0010", state);
    end
    tick();
    settle();
    checks++;
    if (state !== 4'b0100 || idle !== 1'b1 || pop !== 4'b0 || push !== 4'b0) begin
      errors++;
      $display("FAIL idle_state state=%b idle=%b pop=%b push=%b exp 0100/1/0/0",
               state, idle, pop, push);
    end
    tick();
  endtask

  task automatic test_all_ports();
    go_idle();
    fe = 4'h0; af = 4'h0;
    p[0] = 10'h005; p[1] = 10'h105; p[2] = 10'h205; p[3] = 10'h305;
    settle();
    tick();
    for (int k = 0; k < 5; k++) begin
      settle();
      checks++;
      if (pop !== exp_pop || (k < 4 && pop !== 4'(1 << k))) begin
        errors++; $display("FAIL all_pop k=%0d got=%b exp=%b", k, pop, exp_pop);
      end
      if (k > 0) begin
        checks++;
        if (push !== 4'(1 << (k - 1)) || push !== exp_push || got_out !== exp_out) begin
          errors++;
          $display("FAIL all_push k=%0d push=%b out=%h exp=%b/%h",
                   k, push, got_out, exp_push, exp_out);
        end
      end
      tick();
    end
  endtask

  task automatic test_same_dest();
    go_idle();
    fe = 4'b1010; af = 4'h0;
    p[0] = 10'h105; p[1] = 10'h3FF; p[2] = 10'h1AA; p[3] = 10'h0FF;
    settle();
    tick();
    for (int k = 0; k < 5; k++) begin
      settle();
      checks++;
      if (pop !== exp_pop || pop !== ((k % 2) ? 4'b0100 : 4'b0001)) begin
        errors++; $display("FAIL same_pop k=%0d got=%b exp=%b", k, pop, exp_pop);
      end
      if (k > 0) begin
        checks++;
        if (push !== 4'b0010 || got_out !== exp_out) begin
          errors++;
          $display("FAIL same_push k=%0d push=%b out=%h exp=0010/%h",
                   k, push, got_out, exp_out);
        end
      end
      tick();
    end
  endtask

  task automatic test_almost_full();
    go_idle();
    fe = 4'b1100; af = 4'b1000;
    p[0] = 10'h311; p[1] = 10'h022; p[2] = 10'h0; p[3] = 10'h0;
    settle();
    tick();
    for (int k = 0; k < 4; k++) begin
      settle();
      checks++;
      if (pop !== 4'b0010 || pop !== exp_pop) begin
        errors++; $display("FAIL af_pop k=%0d got=%b exp=0010", k, pop);
      end
      tick();
    end
    af = 4'b0000;
    settle();
    checks++;
    if (pop !== 4'b0001 || pop !== exp_pop) begin
      errors++; $display("FAIL af_release got=%b exp=0001", pop);
    end
    tick();
    settle();
    checks++;
    if (push !== 4'b1000 || o3 !== 10'h311) begin
      errors++; $display("FAIL af_push push=%b o3=%h exp=1000/311", push, o3);
    end
    tick();
  endtask

  task automatic test_zero_word();
    go_idle();
    fe = 4'b1101; af = 4'h0;
    p[0] = 10'h3FF; p[1] = 10'h000; p[2] = 10'h3FF; p[3] = 10'h3FF;
    settle();
    tick();
    settle();
    checks++;
    if (pop !== 4'b0010) begin
      errors++; $display("FAIL zero_pop got=%b exp=0010", pop);
    end
    tick();
    fe = 4'hF;
    settle();
    checks++;
    if (push !== 4'b0001 || o0 !== 10'h000 || got_out !== 40'b0) begin
      errors++; $display("FAIL zero_push push=%b out=%h exp=0001/0", push, got_out);
    end
    tick();
  endtask

  task automatic test_init_mid();
    go_idle();
    fe = 4'b1110; af = 4'h0;
    p[0] = 10'h2AB; p[1] = 10'h0; p[2] = 10'h0; p[3] = 10'h0;
    settle();
    tick();
    settle();
    checks++;
    if (pop !== 4'b0001) begin
      errors++; $display("FAIL initmid_grant got=%b exp=0001", pop);
    end
    tick();
    init = 1'b1;
    settle();
    checks++;
    if (push !== 4'b0100 || o2 !== 10'h2AB || pop !== 4'b0) begin
      errors++;
      $display("FAIL initmid_drain push=%b o2=%h pop=%b exp=0100/2ab/0", push, o2, pop);
    end
    tick();
    settle();
    checks++;
    if (state !== 4'b0010 || push !== 4'b0 || pop !== 4'b0) begin
      errors++;
      $display("FAIL initmid_state state=%b push=%b pop=%b exp=0010/0/0", state, push, pop);
    end
    tick();
    init = 1'b0;
  endtask

  task automatic test_reset_mid();
    go_idle();
    fe = 4'b1110; af = 4'h0;
    p[0] = 10'h1C3;
    settle();
    tick();
    settle();
    checks++;
    if (pop !== 4'b0001) begin
      errors++; $display("FAIL rstmid_grant got=%b exp=0001", pop);
    end
    tick();
    reset = 1'b1;
    settle();
    checks++;
    if (push !== 4'b0 || got_out !== 40'b0 || pop !== 4'b0) begin
      errors++;
      $display("FAIL rstmid_drop push=%b out=%h pop=%b exp all 0", push, got_out, pop);
    end
    tick();
    reset = 1'b0;
    settle();
    checks++;
    if (state !== 4'b0001 || push !== 4'b0) begin
      errors++; $display("FAIL rstmid_state state=%b push=%b exp=0001/0", state, push);
    end
    tick();
  endtask

  task automatic test_random();
    go_idle();
    for (int n = 0; n < 400; n++) begin
      fe    = 4'($urandom);
      af    = 4'($urandom) & 4'($urandom);
      for (int i = 0; i < 4; i++) p[i] = 10'($urandom);
      init  = ($urandom_range(0, 39) == 0);
      reset = ($urandom_range(0, 99) == 0);
      settle();
      checks++;
      if (pop !== exp_pop) begin
        errors++; $display("FAIL rnd_pop n=%0d got=%b exp=%b", n, pop, exp_pop);
      end
      checks++;
      if (push !== exp_push || got_out !== exp_out) begin
        errors++;
        $display("FAIL rnd_push n=%0d push=%b out=%h exp=%b/%h",
                 n, push, got_out, exp_push, exp_out);
      end
      checks++;
      if (state !== m_state || idle !== exp_idle) begin
        errors++;
        $display("FAIL rnd_state n=%0d state=%b idle=%b exp=%b/%b",
                 n, state, idle, m_state, exp_idle);
      end
      tick();
    end
    reset = 1'b0;
    init  = 1'b0;
  endtask

  initial begin
    m_state = 4'b0001; m_last = 3; m_pv = 0; m_pd = 0; m_pw = '0;
    test_reset();
    test_all_ports();
    test_same_dest();
    test_almost_full();
    test_zero_word();
    test_init_mid();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
